mipi_csi_rx_packet_sequencer_4lane: RTL

- Sits between the 4-lane byte/lane aligner and the 4-lane RAW depacker in the CSI-2 receive path.
- On a 4-lane-aligned 32-bit word stream it does the following:
  - parses the packet header;
  - filters on virtual channel;
  - decodes the data type into the depacker packet_type code;
  - counts payload words from the word count;
  - strips the CRC and trailer;
  - tracks frame/line state from short packets.
- Gates the depacker's data_valid so that only payload bytes of supported RAW long packets reach it.

---
 rtl/mipi_csi_pkg.sv | 42 ++++
 rtl/mipi_csi_header_decode.sv | 46 ++++
 rtl/mipi_csi_rx_packet_sequencer_4lane.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mipi_csi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mipi_csi_pkg: shared CSI-2 data types, packet_type codes, slices.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mipi_csi_pkg;

  localparam logic [5:0] c_DT_FS    = 6'h00;
  localparam logic [5:0] c_DT_FE    = 6'h01;
  localparam logic [5:0] c_DT_LS    = 6'h02;
  localparam logic [5:0] c_DT_LE    = 6'h03;
  localparam logic [5:0] c_DT_RAW8  = 6'h2A;
  localparam logic [5:0] c_DT_RAW10 = 6'h2B;
  localparam logic [5:0] c_DT_RAW12 = 6'h2C;
  localparam logic [5:0] c_DT_RAW14 = 6'h2D;

  localparam logic [2:0] c_PT_RAW8  = 3'd0;
  localparam logic [2:0] c_PT_RAW10 = 3'd1;
  localparam logic [2:0] c_PT_RAW12 = 3'd2;
  localparam logic [2:0] c_PT_RAW14 = 3'd3;

  // Header word layout: DI in lane0, WC little-endian in lanes 1-2, ECC in lane3.
  localparam int c_DI_LSB  = 0;
  localparam int c_WC_LSB  = 8;
  localparam int c_ECC_LSB = 24;

  typedef enum logic [2:0] {
    DT_CLS_FS    = 3'd0,
    DT_CLS_FE    = 3'd1,
    DT_CLS_LSLE  = 3'd2,
    DT_CLS_RAW   = 3'd3,
    DT_CLS_OTHER = 3'd4
  } dt_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mipi_csi_header_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mipi_csi_header_decode: splits a header word, classifies the DT.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mipi_csi_header_decode
  import mipi_csi_pkg::*;
#(
  parameter logic [15:0] MAX_WC = 16'd16384
) (
  input  logic [23:0] i_header,
  output logic [1:0]  o_vc,
  output logic [15:0] o_wc,
  output dt_class_e   o_dt_class,
  output logic        o_wc_ok,
  output logic [2:0]  o_packet_type,
  output logic [14:0] o_words_left
);

  logic [5:0] w_dt;

  assign o_vc    = i_header[c_DI_LSB+6 +: 2];
  assign w_dt    = i_header[c_DI_LSB +: 6];
  assign o_wc    = {i_header[c_WC_LSB+8 +: 8], i_header[c_WC_LSB +: 8]};
  assign o_wc_ok = (o_wc != 16'd0) && (o_wc <= MAX_WC);
  // 17-bit sum so WC near 0xFFFF cannot wrap before the divide by four.
  assign o_words_left = 15'(({1'b0, o_wc} + 17'd3) >> 2);

  always_comb begin
    o_dt_class    = DT_CLS_OTHER;
    o_packet_type = c_PT_RAW8;
    case (w_dt)
      c_DT_FS:    o_dt_class = DT_CLS_FS;
      c_DT_FE:    o_dt_class = DT_CLS_FE;
      c_DT_LS,
      c_DT_LE:    o_dt_class = DT_CLS_LSLE;
      c_DT_RAW8:  begin o_dt_class = DT_CLS_RAW; o_packet_type = c_PT_RAW8;  end
      c_DT_RAW10: begin o_dt_class = DT_CLS_RAW; o_packet_type = c_PT_RAW10; end
      c_DT_RAW12: begin o_dt_class = DT_CLS_RAW; o_packet_type = c_PT_RAW12; end
      c_DT_RAW14: begin o_dt_class = DT_CLS_RAW; o_packet_type = c_PT_RAW14; end
      default:    o_dt_class = DT_CLS_OTHER;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mipi_csi_rx_packet_sequencer_4lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mipi_csi_rx_packet_sequencer_4lane: header parse, VC filter and    |
// | payload gating between the lane aligner and the RAW depacker.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mipi_csi_rx_packet_sequencer_4lane
  import mipi_csi_pkg::*;
#(
  parameter logic [1:0]  VC_SEL = 2'd0,
  parameter logic [15:0] MAX_WC = 16'd16384
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [31:0] data_i,
  output logic        payload_valid_o,
  output logic [31:0] payload_o,
  output logic        payload_last_o,
  output logic [2:0]  packet_type_o,
  output logic        frame_valid_o,
  output logic        line_valid_o,
  output logic [15:0] frame_number_o,
  output logic [15:0] line_count_o,
  output logic        err_type_o,
  output logic        err_wc_o,
  output logic        err_trunc_o
);

  seq_state_e  r_state;
  logic [14:0] r_words_left;
  logic [1:0]  r_tail_bytes;

  logic [1:0]  w_vc;
  logic [15:0] w_wc;
  dt_class_e   w_dt_class;
  logic        w_wc_ok;
  logic [2:0]  w_packet_type;
  logic [14:0] w_words_left;
  logic [31:0] w_keep_mask;
  logic [31:0] w_payload;

  mipi_csi_header_decode #(
    .MAX_WC (MAX_WC)
  ) u_header_decode (
    .i_header      (data_i[23:0]),
    .o_vc          (w_vc),
    .o_wc          (w_wc),
    .o_dt_class    (w_dt_class),
    .o_wc_ok       (w_wc_ok),
    .o_packet_type (w_packet_type),
    .o_words_left  (w_words_left)
  );

  // WC mod 4 gives the live byte count of the final word (0 means all four).
  always_comb begin
    w_keep_mask = 32'hFFFF_FFFF;
    case (r_tail_bytes)
      2'd1:    w_keep_mask = 32'h0000_00FF;
      2'd2:    w_keep_mask = 32'h0000_FFFF;
      2'd3:    w_keep_mask = 32'h00FF_FFFF;
      default: w_keep_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign w_payload = (r_words_left == 15'd1) ? (data_i & w_keep_mask) : data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state         <= ST_IDLE;
      r_words_left    <= '0;
      r_tail_bytes    <= '0;
      payload_valid_o <= 1'b0;
      payload_o       <= '0;
      payload_last_o  <= 1'b0;
      packet_type_o   <= '0;
      frame_valid_o   <= 1'b0;
      line_valid_o    <= 1'b0;
      frame_number_o  <= '0;
      line_count_o    <= '0;
      err_type_o      <= 1'b0;
      err_wc_o        <= 1'b0;
      err_trunc_o     <= 1'b0;
    end else begin
      payload_valid_o <= 1'b0;
      payload_last_o  <= 1'b0;
      err_type_o      <= 1'b0;
      err_wc_o        <= 1'b0;
      err_trunc_o     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_valid_i) begin
            r_state <= ST_DRAIN;
            if (w_vc == VC_SEL) begin
              case (w_dt_class)
                DT_CLS_FS: begin
                  frame_valid_o  <= 1'b1;
                  frame_number_o <= w_wc;
                  line_count_o   <= '0;
                end
                DT_CLS_FE:   frame_valid_o <= 1'b0;
                DT_CLS_LSLE: ;
                DT_CLS_RAW: begin
                  if (w_wc_ok) begin
                    packet_type_o <= w_packet_type;
                    r_words_left  <= w_words_left;
                    r_tail_bytes  <= w_wc[1:0];
                    line_valid_o  <= 1'b1;
                    r_state       <= ST_PAYLOAD;
                  end else begin
                    err_wc_o <= 1'b1;
                  end
                end
                default: err_type_o <= 1'b1;
              endcase
            end
          end
        end
        ST_PAYLOAD: begin
          if (data_valid_i) begin
            payload_valid_o <= 1'b1;
            payload_o       <= w_payload;
            r_words_left    <= r_words_left - 15'd1;
            if (r_words_left == 15'd1) begin
              payload_last_o <= 1'b1;
              line_count_o   <= line_count_o + 16'd1;
              r_state        <= ST_DRAIN;
            end
          end else begin
            err_trunc_o  <= 1'b1;
            line_valid_o <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          // line_valid_o spans the last payload word, then drops here.
          line_valid_o <= 1'b0;
          if (!data_valid_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
